// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl
//   Run-time controller for a programmable integer clock divider / strobe source.
//   It owns the divide ratio. New ratios are accepted over a valid/ready port and
//   take effect only at a period boundary, so clk_out and tick_out never show a
//   truncated or glitched period. en starts and stops the divider, and a stop also
//   waits for the end of the current period.
//
//   Ports
//     clk_in      : sole clock, rising edge
//     rst_n       : synchronous, active-low reset
//     en          : run request (level)
//     cfg_valid   : a new ratio is offered
//     cfg_div     : offered ratio, legal when >= 2
//     cfg_ready   : controller can accept a ratio (no ratio pending)
//     cfg_err     : one-cycle pulse after an illegal ratio was accepted and dropped
//     clk_out     : divided clock, high for floor(div/2) of every div cycles
//     tick_out    : one-cycle strobe on the last cycle of each period
//     busy        : divider running
//     active_div  : ratio currently in effect
module div_ratio_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick_out,
    output logic             busy,
    output logic [CNT_W-1:0] active_div
);

    if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default
        $error("div_ratio_ctrl: DEFAULT_DIV out of range");
    end

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_n;
    logic [CNT_W-1:0] pend_div, pend_n;

    logic             xfer;
    logic             legal_xfer;
    logic             boundary;

    logic             clk_d, tick_d, busy_d, ready_d, err_d;

    // cfg_ready is a flop that always mirrors "state != PEND", so the handshake
    // can be judged from the registered state directly.
    assign xfer       = cfg_valid && cfg_ready;
    assign legal_xfer = xfer && (cfg_div >= CNT_W'(2));
    assign boundary   = (cnt == active_div - CNT_W'(1));

    // State register. The outputs are registered alongside it from the decode of
    // the next state, so each output equals the decode of the current state while
    // still coming straight from a flop.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= STOP;
            cnt        <= '0;
            active_div <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            clk_out    <= 1'b0;
            tick_out   <= 1'b0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            active_div <= div_n;
            pend_div   <= pend_n;
            clk_out    <= clk_d;
            tick_out   <= tick_d;
            busy       <= busy_d;
            cfg_ready  <= ready_d;
            cfg_err    <= err_d;
        end
    end

    // Next-state logic. Ratio changes and stops only ever land on the boundary
    // while running; in STOP a legal ratio is applied directly.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = active_div;
        pend_n  = pend_div;
        case (state)
            STOP: begin
                cnt_n = '0;
                if (legal_xfer) div_n = cfg_div;
                if (en) state_n = RUN;
            end
            RUN: begin
                if (boundary) begin
                    cnt_n = '0;
                    if (legal_xfer && en) begin
                        // Ratio offered on the boundary waits a full period.
                        pend_n  = cfg_div;
                        state_n = PEND;
                    end else if (legal_xfer) begin
                        // Stopping anyway, so the ratio can be applied now.
                        div_n   = cfg_div;
                        state_n = STOP;
                    end else if (!en) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (legal_xfer) begin
                        pend_n  = cfg_div;
                        state_n = PEND;
                    end
                end
            end
            PEND: begin
                if (boundary) begin
                    cnt_n   = '0;
                    div_n   = pend_div;
                    state_n = en ? RUN : STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = STOP;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode of the next state, captured by the output flops.
    always_comb begin
        busy_d  = (state_n != STOP);
        clk_d   = busy_d && (cnt_n < (div_n >> 1));
        tick_d  = busy_d && (cnt_n == div_n - CNT_W'(1));
        ready_d = (state_n != PEND);
        err_d   = xfer && !legal_xfer;
    end

endmodule
